gemm_tile_sequencer: RTL and testbench
======================================

GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 Parameters (name, default, meaning): BLK_M, 16, tile rows; BLK_N, SUPER_SYS_ROWS, tile output cols; BLK_K, SUPER_SYS_COLS, tile reduction depth; BASE_ADDR, 32'h9000_0000, gemm register base.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, launch job; sampled only in IDLE.
- cfg_m / cfg_n / cfg_k, in, 16 each, matrix dims M, N, K.
- cfg_a_addr / cfg_b_addr / cfg_c_addr, in, 32 each, matrix base addresses.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle completion pulse.
- system_bus_en, out, 1, bus request.
- system_bus_rdwr, out, 1, 1 = write, 0 = read.
- system_bus_addr, out, 32, gemm register address.
- system_bus_wr_data, out, 32, write data.
- system_bus_rd_data, in, 32, gemm read data, valid the cycle after a read request.

Function
REQ-003 States: IDLE, WRITE, POLL_FULL, POLL_DONE, FINISH.
REQ-004 IDLE: bus outputs are en=0, rdwr=0, addr=0, wr_data=0.
REQ-005 start=1 in IDLE latches all cfg_* inputs and sets busy=1. start while busy is ignored.
REQ-006 A start with any of cfg_m, cfg_n, cfg_k equal to 0 goes directly to FINISH with no bus traffic.
REQ-007 Tile loop order: n (step BLK_N) outermost, then m (step BLK_M), then k (step BLK_K) innermost.
REQ-008 Tile sizes: msize=min(BLK_M,M-m), nsize=min(BLK_N,N-n), ksize=min(BLK_K,K-k).
REQ-009 Flags: first=(k==0); last=(k+BLK_K>=K).
REQ-010 Tile addresses, all 32-bit modulo 2^32:
- A = a_addr + k + m*K.
- B = b_addr + n + (k+ksize-1)*N.
- C = c_addr + n + m*N.
- Incremental adders are permitted in place of multipliers.
REQ-011 WRITE issues seven consecutive one-cycle writes (en=1, rdwr=1), in this order:
- +12 = K
- +16 = N
- +0 = tile A address
- +4 = tile B address
- +8 = tile C address
- +20 = {30'b0, first, last}
- +24 = msize | ksize<<5 | nsize<<10
REQ-012 POLL_FULL drives en=1, rdwr=0, addr=BASE_ADDR every cycle.
- rd_data is ignored in the first POLL_FULL cycle.
- From the second cycle on, rd_data[0]==0 ends the poll; otherwise polling continues indefinitely.
REQ-013 After POLL_FULL ends, the next tile's WRITE begins on the next cycle, or POLL_DONE begins if that was the final tile. No idle cycle is inserted.
REQ-014 POLL_DONE polls addr=BASE_ADDR+24 with the same read protocol as REQ-012, exiting on rd_data[0]==1.
REQ-015 FINISH lasts one cycle: done=1, busy=0 from that cycle, bus idle, then IDLE.
REQ-016 Tile count per job = ceil(N/BLK_N)*ceil(M/BLK_M)*ceil(K/BLK_K). Each tile produces exactly 7 writes.
REQ-017 Minimum latency per tile = 9 cycles (7 writes + 2 poll cycles).
REQ-018 Changes to cfg_* inputs while busy have no effect on the current job.

Reset
REQ-019 rst=1 asynchronously forces IDLE with busy=0, done=0 and all bus outputs 0, including mid-write or mid-poll. All loop counters clear to 0.
REQ-020 After rst deasserts, the block takes no action until a new start.

Verification
REQ-021 M=N=K=16, BLK_*=16, a=0, b=256, c=512, rd_data=0:
- Writes 16, 16, 0, 496, 512, 3, 16912 to +12, +16, +0, +4, +8, +20, +24.
- Then polls +0 and +24.
- With rd_data[0]=1 at +24, done pulses once.
REQ-022 M=N=K=20, BLK_*=16:
- Exactly 8 tiles (56 writes).
- Tile 1: control=2, dim=16912.
- Tile 2: control=1, B=b+380, dim=16|4<<5|16<<10.
- Last tile: dim=4228, C=c+16+320.
REQ-023 Hold rd_data[0]=1 for 5 cycles during POLL_FULL:
- No write is issued during those cycles.
- The next tile's first write appears the cycle after rd_data[0] first reads 0.
REQ-024 Assert rst during the 4th write of a tile: bus outputs and busy go 0 immediately. A new start restarts from tile (n=0, m=0, k=0).
REQ-025 start with cfg_k=0: no bus transaction, done pulses one cycle later, busy is high for one cycle. start asserted while busy: job results are unchanged.

Source files
------------

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: walks a GEMM job tile by tile, programming gemm registers and polling status.
// Ports: clk/rst (async active-high); start + cfg_m/n/k + cfg_a/b/c_addr launch a job;
// busy/done report progress; system_bus_* is a one-request-per-cycle register bus
// (rd_data returns the cycle after a read request).
module gemm_tile_sequencer #(
    parameter int          SUPER_SYS_ROWS = 16,
    parameter int          SUPER_SYS_COLS = 16,
    parameter int          BLK_M          = 16,
    parameter int          BLK_N          = SUPER_SYS_ROWS,
    parameter int          BLK_K          = SUPER_SYS_COLS,
    parameter logic [31:0] BASE_ADDR      = 32'h9000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cfg_m,
    input  logic [15:0] cfg_n,
    input  logic [15:0] cfg_k,
    input  logic [31:0] cfg_a_addr,
    input  logic [31:0] cfg_b_addr,
    input  logic [31:0] cfg_c_addr,
    output logic        busy,
    output logic        done,
    output logic        system_bus_en,
    output logic        system_bus_rdwr,
    output logic [31:0] system_bus_addr,
    output logic [31:0] system_bus_wr_data,
    input  logic [31:0] system_bus_rd_data
);
    localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, POLL_FULL = 3'd2, POLL_DONE = 3'd3, FINISH = 3'd4;
    localparam logic [31:0] BM = 32'(BLK_M), BN = 32'(BLK_N), BK = 32'(BLK_K);

    logic [2:0]  state, widx;
    logic        polled;
    logic [15:0] m_i, n_i, k_i, cm, cn, ck;
    logic [31:0] ca, cb, cc;
    logic [31:0] mw, nw, kw, mm, nn, kk, msize, nsize, ksize, m_end, n_end, k_end;
    logic [31:0] a_t, b_t, c_t, dim, off, wdat;
    logic        first, last, final_tile, writing, pf, pd, rd_unused;

    assign mw = 32'(m_i);
    assign nw = 32'(n_i);
    assign kw = 32'(k_i);
    assign mm = 32'(cm);
    assign nn = 32'(cn);
    assign kk = 32'(ck);
    assign msize = (mm - mw < BM) ? mm - mw : BM;
    assign nsize = (nn - nw < BN) ? nn - nw : BN;
    assign ksize = (kk - kw < BK) ? kk - kw : BK;
    assign m_end = mw + BM;
    assign n_end = nw + BN;
    assign k_end = kw + BK;
    assign first = k_i == 16'd0;
    assign last = k_end >= kk;
    assign final_tile = last && m_end >= mm && n_end >= nn;
    assign a_t = ca + kw + mw * kk;
    // B points at the last row of the k-slice being consumed
    assign b_t = cb + nw + (kw + ksize - 32'd1) * nn;
    assign c_t = cc + nw + mw * nn;
    assign dim = msize | (ksize << 5) | (nsize << 10);
    assign rd_unused = ^system_bus_rd_data[31:1];

    always_comb begin
        off  = 32'd24;
        wdat = dim;
        case (widx)
            3'd0: begin off = 32'd12; wdat = kk; end
            3'd1: begin off = 32'd16; wdat = nn; end
            3'd2: begin off = 32'd0;  wdat = a_t; end
            3'd3: begin off = 32'd4;  wdat = b_t; end
            3'd4: begin off = 32'd8;  wdat = c_t; end
            3'd5: begin off = 32'd20; wdat = {30'b0, first, last}; end
            default: begin off = 32'd24; wdat = dim; end
        endcase
    end

    assign writing = state == WRITE;
    assign pf = state == POLL_FULL;
    assign pd = state == POLL_DONE;
    assign system_bus_en = writing | pf | pd;
    assign system_bus_rdwr = writing;
    assign system_bus_addr = writing ? BASE_ADDR + off : pf ? BASE_ADDR : pd ? BASE_ADDR + 32'd24 : 32'd0;
    assign system_bus_wr_data = writing ? wdat : 32'd0;
    // busy rises in the accepting cycle so a zero-sized job still shows one busy cycle
    assign busy = !rst && (state == IDLE ? start : state != FINISH);
    assign done = state == FINISH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            widx   <= '0;
            polled <= 1'b0;
            m_i    <= '0;
            n_i    <= '0;
            k_i    <= '0;
            cm     <= '0;
            cn     <= '0;
            ck     <= '0;
            ca     <= '0;
            cb     <= '0;
            cc     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cm    <= cfg_m;
                    cn    <= cfg_n;
                    ck    <= cfg_k;
                    ca    <= cfg_a_addr;
                    cb    <= cfg_b_addr;
                    cc    <= cfg_c_addr;
                    m_i   <= '0;
                    n_i   <= '0;
                    k_i   <= '0;
                    widx  <= '0;
                    state <= (cfg_m == 16'd0 || cfg_n == 16'd0 || cfg_k == 16'd0) ? FINISH : WRITE;
                end
                WRITE: begin
                    widx   <= (widx == 3'd6) ? 3'd0 : widx + 3'd1;
                    polled <= 1'b0;
                    if (widx == 3'd6) state <= POLL_FULL;
                end
                // the first poll cycle only issues the read; its rd_data belongs to an older request
                POLL_FULL: begin
                    polled <= 1'b1;
                    if (polled && !system_bus_rd_data[0]) begin
                        polled <= 1'b0;
                        state  <= final_tile ? POLL_DONE : WRITE;
                        if (!final_tile) begin
                            if (!last) k_i <= k_end[15:0];
                            else begin
                                k_i <= '0;
                                if (m_end < mm) m_i <= m_end[15:0];
                                else begin
                                    m_i <= '0;
                                    n_i <= n_end[15:0];
                                end
                            end
                        end
                    end
                end
                POLL_DONE: begin
                    polled <= 1'b1;
                    if (polled && system_bus_rd_data[0]) state <= FINISH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: scoreboard bench for gemm_tile_sequencer with a scripted gemm responder.
module tb_gemm_tile_sequencer;
    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
    logic [31:0] cfg_a_addr = '0, cfg_b_addr = '0, cfg_c_addr = '0;
    logic        busy, done, system_bus_en, system_bus_rdwr;
    logic [31:0] system_bus_addr, system_bus_wr_data;
    logic [31:0] system_bus_rd_data = '0;

    gemm_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .cfg_a_addr(cfg_a_addr), .cfg_b_addr(cfg_b_addr), .cfg_c_addr(cfg_c_addr),
        .busy(busy), .done(done),
        .system_bus_en(system_bus_en), .system_bus_rdwr(system_bus_rdwr),
        .system_bus_addr(system_bus_addr), .system_bus_wr_data(system_bus_wr_data),
        .system_bus_rd_data(system_bus_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int hold_full = 0, hold_done = 0;
    int writes = 0, full_reads = 0, done_reads = 0, bad_reads = 0, done_cnt = 0, done_cyc = 0;
    int start_cyc = 0, last_w = 0;
    bit fresh = 1'b0;
    logic [63:0] exp_q[$];
    int run_f = 0, run_d = 0;

    // gemm model: full-status reads answer 1 for the first hold_full reads of a poll run,
    // done-status reads answer 0 for the first hold_done reads; anything else returns all-ones
    always @(posedge clk) begin
        if (system_bus_en && !system_bus_rdwr && system_bus_addr == BASE) begin
            system_bus_rd_data <= (run_f < hold_full) ? 32'd1 : 32'd0;
            run_f <= run_f + 1;
            run_d <= 0;
        end else if (system_bus_en && !system_bus_rdwr && system_bus_addr == BASE + 32'd24) begin
            system_bus_rd_data <= (run_d < hold_done) ? 32'd0 : 32'd1;
            run_d <= run_d + 1;
            run_f <= 0;
        end else begin
            system_bus_rd_data <= 32'hFFFF_FFFF;
            run_f <= 0;
            run_d <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // observe one cycle at the falling edge, then advance to just past the next rising edge
    task automatic step();
        logic [63:0] e;
        @(negedge clk);
        if (system_bus_en && system_bus_rdwr) begin
            writes++;
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr_data", {system_bus_addr, system_bus_wr_data}, e);
                chk("write_cycle", 64'(cyc),
                    64'(fresh ? start_cyc : last_w + ((e[63:32] == BASE + 32'd12) ? 3 + hold_full : 1)));
                fresh  = 1'b0;
                last_w = cyc;
            end
        end
        if (system_bus_en && !system_bus_rdwr) begin
            if (system_bus_addr == BASE) full_reads++;
            else if (system_bus_addr == BASE + 32'd24) done_reads++;
            else bad_reads++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("finish_idle", {63'd0, busy | system_bus_en}, 64'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_tile(input logic [31:0] k, n, a, b, c, ctl, dm);
        exp_q.push_back({BASE + 32'd12, k});
        exp_q.push_back({BASE + 32'd16, n});
        exp_q.push_back({BASE, a});
        exp_q.push_back({BASE + 32'd4, b});
        exp_q.push_back({BASE + 32'd8, c});
        exp_q.push_back({BASE + 32'd20, ctl});
        exp_q.push_back({BASE + 32'd24, dm});
    endtask

    task automatic push_job(input int mm, nn, kk, input logic [31:0] a, b, c);
        int ms, ns, ks;
        for (int n = 0; n < nn; n += 16)
            for (int m = 0; m < mm; m += 16)
                for (int k = 0; k < kk; k += 16) begin
                    ms = (mm - m < 16) ? mm - m : 16;
                    ns = (nn - n < 16) ? nn - n : 16;
                    ks = (kk - k < 16) ? kk - k : 16;
                    push_tile(32'(kk), 32'(nn), a + 32'(k) + 32'(m * kk), b + 32'(n) + 32'((k + ks - 1) * nn),
                              c + 32'(n) + 32'(m * nn), {30'd0, k == 0, k + 16 >= kk},
                              32'(ms | (ks << 5) | (ns << 10)));
                end
    endtask

    task automatic run_job(input int m, n, k, input logic [31:0] a, b, c, input int hf, hd, input bit poke);
        int t, s, w0, fr0, dr0, dc0;
        bit zero;
        t = exp_q.size() / 7;
        zero = (m == 0 || n == 0 || k == 0);
        hold_full = hf;
        hold_done = hd;
        cfg_m = 16'(m); cfg_n = 16'(n); cfg_k = 16'(k);
        cfg_a_addr = a; cfg_b_addr = b; cfg_c_addr = c;
        w0 = writes; fr0 = full_reads; dr0 = done_reads; dc0 = done_cnt;
        start = 1'b1;
        #1;
        chk("busy_on_start", {63'd0, busy}, 64'd1);
        step();
        start = 1'b0;
        s = cyc;
        start_cyc = s;
        fresh = 1'b1;
        for (int i = 0; i < 5000 && done_cnt == dc0; i++) begin
            if (poke && i == 3) begin
                start = 1'b1;
                cfg_m = 16'd3; cfg_n = 16'd5; cfg_k = 16'd0;
                cfg_a_addr = 32'hDEAD_0000; cfg_b_addr = 32'h1234_5678; cfg_c_addr = 32'h1;
            end else if (poke && i == 4) start = 1'b0;
            step();
        end
        chk("done_pulse", 64'(done_cnt - dc0), 64'd1);
        step();
        chk("done_single", 64'(done_cnt - dc0), 64'd1);
        chk("idle_after", {62'd0, busy, system_bus_en}, 64'd0);
        chk("write_count", 64'(writes - w0), 64'(7 * t));
        chk("full_polls", 64'(full_reads - fr0), 64'(zero ? 0 : t * (2 + hf)));
        chk("done_polls", 64'(done_reads - dr0), 64'(zero ? 0 : 2 + hd));
        chk("done_cycle", 64'(done_cyc), 64'(zero ? s : s + t * (9 + hf) + 2 + hd));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("bad_reads", 64'(bad_reads), 64'd0);
    endtask

    initial begin
        int bound;
        repeat (3) step();
        chk("reset_outputs", {busy, done, system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data},
            64'd0);
        rst = 1'b0;
        step();
        chk("idle_bus", {busy, done, system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data}, 64'd0);

        push_tile(32'd16, 32'd16, 32'd0, 32'd496, 32'd512, 32'd3, 32'd16912);
        run_job(16, 16, 16, 32'd0, 32'd256, 32'd512, 0, 0, 1'b0);

        push_job(20, 20, 20, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
        run_job(20, 20, 20, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 0, 0, 1'b1);

        push_job(16, 16, 32, 32'hFFFF_FF00, 32'h4000_0000, 32'h5000_0000);
        run_job(16, 16, 32, 32'hFFFF_FF00, 32'h4000_0000, 32'h5000_0000, 5, 3, 1'b0);

        run_job(16, 16, 0, 32'd0, 32'd0, 32'd0, 0, 0, 1'b0);
        run_job(0, 33, 17, 32'd0, 32'd0, 32'd0, 0, 0, 1'b0);

        push_job(20, 20, 20, 32'd100, 32'd200, 32'd300);
        cfg_m = 16'd20; cfg_n = 16'd20; cfg_k = 16'd20;
        cfg_a_addr = 32'd100; cfg_b_addr = 32'd200; cfg_c_addr = 32'd300;
        hold_full = 0; hold_done = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        fresh = 1'b1;
        bound = 0;
        while (!(system_bus_en && system_bus_rdwr && system_bus_addr == BASE + 32'd4) && bound < 50) begin
            step();
            bound++;
        end
        chk("reach_4th_write", 64'(bound < 50), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_reset", {busy, done, system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data},
            64'd0);
        step();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("quiet_after_reset", {62'd0, busy, system_bus_en}, 64'd0);
        end
        push_job(20, 20, 20, 32'd100, 32'd200, 32'd300);
        run_job(20, 20, 20, 32'd100, 32'd200, 32'd300, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
